// File: rtl/da_fir_engine.sv
// da_fir_engine: bit-serial distributed-arithmetic MAC for a 64-tap FIR with 16-bit samples.
// Eight 256-entry LUTs of coefficient partial sums are shift-accumulated over a 16-cycle frame.
module da_fir_engine #(
  parameter logic [1023:0] COEFS = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  x1_bit,
  input  logic [7:0]  x2_bit,
  input  logic [7:0]  x3_bit,
  input  logic [7:0]  x4_bit,
  input  logic [7:0]  x5_bit,
  input  logic [7:0]  x6_bit,
  input  logic [7:0]  x7_bit,
  input  logic [7:0]  x8_bit,
  output logic [31:0] sum
);
  function automatic logic signed [18:0] lut_entry(input int k, input int a);
    logic signed [18:0] s;
    logic [15:0] c;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      c = COEFS[16*(8*k+j) +: 16];
      if (a[j]) s = s + {{3{c[15]}}, c};
    end
    return s;
  endfunction

  logic [63:0]        x;
  logic signed [18:0] lut [8][256];
  logic signed [21:0] p;
  logic signed [37:0] sh, acc_q, acc_d;
  logic [31:0]        sum_d;
  logic [3:0]         cnt_q;

  assign x = {x8_bit, x7_bit, x6_bit, x5_bit, x4_bit, x3_bit, x2_bit, x1_bit};

  for (genvar k = 0; k < 8; k++) begin : g_lut
    for (genvar a = 0; a < 256; a++) begin : g_ent
      assign lut[k][a] = lut_entry(k, a);
    end
  end

  // The sign-bit slice (cnt 15) carries weight -2^15, so it is subtracted.
  always_comb begin
    p = '0;
    for (int k = 0; k < 8; k++) p = p + 22'(lut[k][x[8*k +: 8]]);
    sh = 38'(p) << cnt_q;
    acc_d = (cnt_q == 4'd15) ? '0 : acc_q + sh;
    sum_d = acc_q[31:0] - sh[31:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      sum   <= '0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
      acc_q <= acc_d;
      if (cnt_q == 4'd15) sum <= sum_d;
    end
  end
endmodule

// File: tb/tb_da_fir_engine.sv
// tb_da_fir_engine: six engines with different coefficient sets share one sample stream;
// a scoreboard compares each frame result against plain dot-product arithmetic.
module tb_da_fir_engine;
  typedef logic [5:0][31:0] exp_t;

  function automatic logic [1023:0] rand_coefs();
    logic [31:0] s;
    logic [1023:0] r;
    s = 32'h1234_5678;
    r = '0;
    for (int t = 0; t < 64; t++) begin
      s = s * 32'd1664525 + 32'd1013904223;
      r[16*t +: 16] = s[31:16];
    end
    return r;
  endfunction

  localparam logic [1023:0] CF [6] = '{
    1024'(1), {64{16'h0001}}, {64{16'h8000}}, 1024'(3), 1024'(16'h8000), rand_coefs()
  };

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] xv = '0;
  logic [31:0] sums [6];
  logic signed [15:0] samp [64];
  exp_t q [$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 6; i++) begin : g_dut
    da_fir_engine #(.COEFS(CF[i])) u_dut (
      .clk(clk), .reset(reset),
      .x1_bit(xv[7:0]), .x2_bit(xv[15:8]), .x3_bit(xv[23:16]), .x4_bit(xv[31:24]),
      .x5_bit(xv[39:32]), .x6_bit(xv[47:40]), .x7_bit(xv[55:48]), .x8_bit(xv[63:56]),
      .sum(sums[i])
    );
  end

  function automatic exp_t model();
    exp_t e;
    logic [1023:0] cv;
    longint a;
    for (int d = 0; d < 6; d++) begin
      cv = CF[d];
      a = 0;
      for (int t = 0; t < 64; t++) a += longint'($signed(cv[16*t +: 16])) * longint'(samp[t]);
      e[d] = a[31:0];
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h exp=%h", nm, d, got, exp);
    end
  endtask

  task automatic send_slice(input int c);
    @(negedge clk);
    for (int t = 0; t < 64; t++) xv[t] = samp[t][c];
  endtask

  task automatic frame();
    for (int c = 0; c < 16; c++) send_slice(c);
    q.push_back(model());
  endtask

  task automatic check_now(input string nm, input int d, input logic [31:0] v);
    @(posedge clk);
    #2 cmp(nm, d, sums[d], v);
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int t = 0; t < 64; t++) samp[t] = v;
  endtask

  task automatic set_tap0(input logic [15:0] v);
    set_all(16'h0);
    samp[0] = v;
  endtask

  // Monitor: a result appears on every 16th edge after reset release and is held in between.
  int ecnt = 0;
  exp_t held = '0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      ecnt = 0;
      held = '0;
    end else begin
      ecnt++;
      if (ecnt == 16) begin
        ecnt = 0;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty got=unexpected_frame exp=queued_result");
        end else begin
          held = q.pop_front();
          for (int d = 0; d < 6; d++) cmp("frame", d, sums[d], held[d]);
        end
      end else begin
        for (int d = 0; d < 6; d++) cmp("hold", d, sums[d], held[d]);
      end
    end
  end

  initial begin
    set_all(16'h0);
    repeat (3) @(posedge clk);
    for (int d = 0; d < 6; d++) cmp("reset", d, sums[d], 32'h0);
    #2 reset = 1'b0;
    set_tap0(16'd5);
    frame();
    check_now("tap0_5", 0, 32'h0000_0005);
    set_tap0(16'hFFFF);
    frame();
    check_now("tap0_m1", 0, 32'hFFFF_FFFF);
    set_all(16'h7FFF);
    frame();
    check_now("all_7fff", 1, 32'h001F_FFC0);
    set_all(16'h8000);
    frame();
    check_now("wrap_8000", 2, 32'h0);
    cmp("tap0_8000", 4, sums[4], 32'h4000_0000);
    set_tap0(16'd2);
    frame();
    check_now("b2b_first", 3, 32'h0000_0006);
    set_tap0(16'hFFFC);
    frame();
    check_now("b2b_second", 3, 32'hFFFF_FFF4);
    for (int f = 0; f < 24; f++) begin
      for (int t = 0; t < 64; t++) samp[t] = 16'($urandom);
      frame();
    end
    set_tap0(16'd5);
    frame();
    for (int c = 0; c < 7; c++) send_slice(c);
    send_slice(7);
    #1 reset = 1'b1;
    #1 for (int d = 0; d < 6; d++) cmp("rst_mid", d, sums[d], 32'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    frame();
    check_now("after_rst", 0, 32'h0000_0005);
    for (int c = 0; c < 16; c++) send_slice(c);
    reset = 1'b1;
    @(posedge clk);
    #2 cmp("rst_cnt15", 0, sums[0], 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int f = 0; f < 4; f++) begin
      for (int t = 0; t < 64; t++) samp[t] = 16'($urandom);
      frame();
    end
    @(posedge clk);
    #3 cmp("sb_drained", 0, 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/da_fir_engine.md
# da_fir_engine

Bit-serial distributed-arithmetic (DA) multiply-accumulate engine for a 64-tap FIR filter with 16-bit two's-complement samples. Each cycle it takes one bit-slice of all 64 tap samples, delivered LSB first from the parallel-to-serial shift registers, and looks up eight precomputed 8-coefficient partial sums. It shift-accumulates them over 16 cycles and publishes one 32-bit filter output per 16-cycle frame. It sits between the tap shift-register chain and the core's `sum` output.

## Interface
- `COEFS`, default all zero (1024 bits): 64 signed 16-bit coefficients; tap t coefficient = `COEFS[16*t +: 16]`.
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `x1_bit`  in  8  bit-slice for taps 0–7; bit j = current bit of tap j sample.
- `x2_bit` … `x8_bit`  in  8 each  bit-slices for taps 8–15 … 56–63; `xk_bit[j]` = tap 8*(k-1)+j.
- `sum`  out  32  filter output, two's complement, held for a full frame.

## Operation
- Eight LUTs, one per `xk_bit` group, 256 entries each.
- Entry a of LUT k = signed sum of the coefficients of taps 8*(k-1)+j for every j where bit j of a is 1. Address 0 → 0.
- LUT contents are derived from `COEFS` at elaboration. There is no runtime load.
- LUT entries are 19-bit signed. Partial P = sign-extended sum of the 8 LUT outputs, 22-bit signed, computed combinationally each cycle.
- A 4-bit bit counter `cnt` runs 0..15 and wraps. `cnt` = weight of the bit currently on the inputs: 0 = LSB, 15 = sign bit.
- 38-bit signed accumulator `acc` (full precision: 16+16+6).
- On each edge with cnt 0..14: `acc <= acc + (P << cnt)`.
- On the edge with cnt 15:
  - final = acc − (P << 15); the sign bit carries weight −2^15.
  - `sum <= final[31:0]`, which wraps modulo 2^32 with no saturation.
  - `acc <= 0`.
- The frame result equals Σ_t COEFS[t]·x_t, where x_t is tap t's signed 16-bit sample serialized over cnt 0..15.
- Inputs must be stable for the whole cycle. No handshake: the producer aligns the LSB slice with cnt = 0, i.e. the first edge after reset release.

## Timing
- Reset (async, any time):
  - `cnt`, `acc` and `sum` go to 0 immediately.
  - Bits already accumulated are discarded. There is no partial output.
- After reset deasserts, the first rising edge samples cnt = 0.
- `sum` updates exactly once per 16 clocks, on the 16th edge of each frame, and is then constant for 16 cycles.
- Latency: the result is visible immediately after the edge that samples the MSB slice. There is no extra pipeline stage.
- Counter wrap 15→0: the accumulator clears and the next frame starts on the very next edge, with no bubble.
- Reset asserted during the cnt = 15 edge: reset wins, and `sum` stays 0.

## Test plan
- COEFS: tap0 = 1, all others 0. Tap0 sample = 5 (slice bits 1,0,1,0…), others 0 → `sum` = 0x00000005 after 16 clocks, held for 16 clocks.
- Same COEFS, tap0 sample = 0xFFFF (−1) → `sum` = 0xFFFFFFFF; sign-bit subtraction is verified.
- All 64 coefficients = 1, all samples = 0x7FFF (all `xk_bit` = 0xFF for cnt 0–14, 0x00 at cnt 15) → `sum` = 0x001FFFC0 (2 097 088).
- All coefficients = 0x8000, all samples = 0x8000. Full value 2^36 → `sum` = 0x00000000 (wrap). Also tap0 only, both 0x8000 → 0x40000000.
- Back-to-back frames, tap0 coef = 3, samples 2 then −4 → `sum` = 6 at edge 16, then 0xFFFFFFF4 at edge 32, with no gap.
- Reset pulse at cnt = 7 mid-frame → `sum` = 0 at once. The next frame is counted from the release, and a full 16-clock frame of sample 5 (tap0 coef 1) yields 5.
